interrupt_ram_copier: RTL and testbench
=======================================

// Module: interrupt_ram_copier
// PURPOSE
//  Avalon-MM master that copies a block of 32-bit words from one word address to another.
//  It drives the s1/s2 slave port of the on-chip RAM: single port, word addressed, fixed read latency.
//  Started by a one-cycle pulse. Raises a level interrupt on completion, which the Nios II ISR clears.
//  Serves as the initiator side of the RAM interface in the interrupt demo system.
// PARAMETERS
//  ADDR_W        16  word-address width, matches the RAM address port
//  DATA_W        32  data width; byteenable width is DATA_W/8
//  LEN_W         16  width of the transfer length in words
//  READ_LATENCY   1  cycles from read acceptance to valid readdata; legal range 1..4
// PORTS
//  clk              in   1           system clock; all logic is on the rising edge
//  reset_n          in   1           asynchronous, active-low reset
//  start            in   1           one-cycle pulse that starts a copy; sampled only in IDLE
//  src_addr         in   ADDR_W      first source word address, latched on start
//  dst_addr         in   ADDR_W      first destination word address, latched on start
//  length           in   LEN_W       number of words to copy, latched on start
//  busy             out  1           high from the cycle after an accepted start until DONE
//  irq              out  1           completion interrupt, level, sticky until cleared
//  irq_ack          in   1           one-cycle pulse that clears irq
//  words_done       out  LEN_W       count of words written in the current or last copy
//  avm_address      out  ADDR_W      master word address
//  avm_chipselect   out  1           equals avm_read | avm_write
//  avm_read         out  1           read request
//  avm_write        out  1           write request
//  avm_byteenable   out  DATA_W/8    always all ones
//  avm_writedata    out  DATA_W      data captured from the source word
//  avm_readdata     in   DATA_W      slave read data
//  avm_waitrequest  in   1           slave stall; tie low for the on-chip RAM
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; busy, irq, avm_read, avm_write, avm_chipselect = 0
//   - avm_address, avm_writedata, words_done = 0; avm_byteenable = all ones
//   - Reset during a copy aborts it at once. No further bus cycles are issued. No irq.
//  FSM states: IDLE, RD, RWAIT, WR, DONE.
//   - IDLE:  start=1 and length!=0 -> latch src/dst/len, clear words_done, go to RD.
//            start=1 and length==0 -> go to DONE; no bus cycles.
//   - RD:    avm_read=1, avm_address=src. The request is held stable while avm_waitrequest=1.
//            Acceptance is the edge with waitrequest=0 -> RWAIT.
//   - RWAIT: lasts exactly READ_LATENCY cycles; avm_read=0.
//            avm_readdata is captured into the write buffer at the final edge of RWAIT -> WR.
//   - WR:    avm_write=1, avm_address=dst, avm_writedata=buffer. The request is held while waitrequest=1.
//            On acceptance: words_done+1, src+1, dst+1, remaining-1.
//            remaining==0 after the decrement -> DONE, else -> RD.
//   - DONE:  single cycle; busy drops at its end; irq set at its end -> IDLE.
//  Timing with waitrequest=0: start at edge E0; first avm_read in cycle E0..E1.
//   - Each word takes 2+READ_LATENCY cycles.
//   - irq is high 1 cycle after the last write is accepted.
//  Addresses increment modulo 2^ADDR_W, so 0xFFFF+1 wraps to 0x0000.
//  Words are copied in ascending order. Overlap with dst>src is not protected; data is corrupted as defined.
//  start while busy (any state other than IDLE) is ignored; latched parameters are unchanged.
//  irq_ack clears irq. If irq_ack and DONE's set event coincide, the set wins and irq=1.
//  avm_read and avm_write are never high in the same cycle. Outputs are registered; no combinational path from inputs.
// TESTING
//  1. len=4, src=0x0010, dst=0x0100, RAM preloaded 0xA0..0xA3, L=1, no wait.
//     -> RAM[0x100..0x103]=0xA0..0xA3, irq high exactly 13 cycles after the start edge, words_done=4.
//  2. Random waitrequest at 50% during len=8.
//     -> address and data stable throughout each stall, exactly 8 reads and 8 writes, data correct.
//  3. len=0 start.
//     -> no avm_read/avm_write ever, irq=1 two cycles later, words_done=0.
//  4. src=0xFFFE, dst=0x0200, len=3.
//     -> reads at 0xFFFE, 0xFFFF, 0x0000 and writes at 0x0200..0x0202.
//  5. start pulsed mid-copy, then reset_n=0 at word 2 of len=6.
//     -> second start ignored; after reset all outputs are 0, no irq, no further bus cycles.
//  6. irq_ack asserted in the same cycle that DONE sets irq.
//     -> irq stays 1; a later lone irq_ack clears it to 0.

Source files
------------

// File: rtl/interrupt_ram_copier_if.sv
// Avalon-MM bus between the copier (master) and the on-chip RAM slave port.
interface interrupt_ram_copier_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_read, avm_write,
    output avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_read, avm_write,
    input  avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/interrupt_ram_copier.sv
// Avalon-MM block copier: reads a word, writes it to the destination, repeats,
// then raises a sticky level interrupt.
module interrupt_ram_copier #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              irq,
  input  logic              irq_ack,
  output logic [LEN_W-1:0]  words_done,
  interrupt_ram_copier_if.master bus
);
  localparam int CNT_W = 3;

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] src_q, src_n, dst_q, dst_n, addr_q, addr_n;
  logic [LEN_W-1:0]  rem_q, rem_n, wd_q, wd_n;
  logic [CNT_W-1:0]  lat_q, lat_n;
  logic [DATA_W-1:0] wdata_q;
  logic              capture;
  logic              read_q, write_q, cs_q, busy_q, irq_q;

  always_comb begin
    state_n = state;
    src_n   = src_q;
    dst_n   = dst_q;
    rem_n   = rem_q;
    lat_n   = lat_q;
    wd_n    = wd_q;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          wd_n = '0;
          if (length != '0) begin
            src_n   = src_addr;
            dst_n   = dst_addr;
            rem_n   = length;
            state_n = RD;
          end else begin
            state_n = DONE;
          end
        end
      end
      RD: begin
        if (!bus.avm_waitrequest) begin
          state_n = RWAIT;
          lat_n   = '0;
        end
      end
      RWAIT: begin
        if (lat_q == CNT_W'(READ_LATENCY - 1)) begin
          state_n = WR;
          capture = 1'b1;
        end else begin
          lat_n = lat_q + 1'b1;
        end
      end
      WR: begin
        if (!bus.avm_waitrequest) begin
          wd_n    = wd_q + 1'b1;
          src_n   = src_q + 1'b1;
          dst_n   = dst_q + 1'b1;
          rem_n   = rem_q - 1'b1;
          state_n = (rem_q == LEN_W'(1)) ? DONE : RD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Bus outputs are registered from the next state, so a request appears the
    // cycle its state is entered and stays frozen while the slave stalls.
    addr_n = addr_q;
    if (state_n == RD)      addr_n = src_n;
    else if (state_n == WR) addr_n = dst_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      cs_q    <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state   <= state_n;
      src_q   <= src_n;
      dst_q   <= dst_n;
      rem_q   <= rem_n;
      lat_q   <= lat_n;
      wd_q    <= wd_n;
      addr_q  <= addr_n;
      read_q  <= (state_n == RD);
      write_q <= (state_n == WR);
      cs_q    <= (state_n == RD) || (state_n == WR);
      busy_q  <= (state_n != IDLE);
      if (capture) wdata_q <= bus.avm_readdata;
      // Completion set takes priority over a coincident acknowledge.
      if (state == DONE)  irq_q <= 1'b1;
      else if (irq_ack)   irq_q <= 1'b0;
    end
  end

  assign busy               = busy_q;
  assign irq                = irq_q;
  assign words_done         = wd_q;
  assign bus.avm_address    = addr_q;
  assign bus.avm_read       = read_q;
  assign bus.avm_write      = write_q;
  assign bus.avm_chipselect = cs_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = '1;
endmodule

// File: tb/tb_interrupt_ram_copier.sv
// Bench for interrupt_ram_copier: RAM slave model with fixed read latency and
// optional random stalls, plus a scoreboard of expected read/write transfers.
module tb_interrupt_ram_copier;
  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_addr = '0, dst_addr = '0, length = '0;
  logic        busy, irq;
  logic        irq_ack = 1'b0;
  logic [15:0] words_done;
  logic        rand_wait = 1'b0;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  logic [15:0] exp_rd_q[$];
  logic [15:0] exp_wa_q[$];
  logic [31:0] exp_wd_q[$];

  logic [31:0] mem [0:65535];
  logic [31:0] rd_pipe [RL];

  interrupt_ram_copier_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  interrupt_ram_copier #(.ADDR_W(16), .DATA_W(32), .LEN_W(16), .READ_LATENCY(RL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .words_done (words_done),
    .bus        (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // RAM slave: fixed-latency read pipeline, writes on acceptance
  always @(posedge clk) begin
    if (bus.avm_write && !bus.avm_waitrequest) mem[bus.avm_address] <= bus.avm_writedata;
    rd_pipe[0] <= (bus.avm_read && !bus.avm_waitrequest) ? mem[bus.avm_address] : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.avm_readdata = rd_pipe[RL-1];

  initial bus.avm_waitrequest = 1'b0;
  always @(posedge clk) begin
    #2;
    bus.avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Bus monitor: sampled mid-cycle, acceptance happens at the following rising edge
  logic        prev_stall = 1'b0, prev_rd = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      chk("rd_wr_excl", 64'(bus.avm_read & bus.avm_write), 64'(0));
      chk("chipselect", 64'(bus.avm_chipselect), 64'(bus.avm_read | bus.avm_write));
      if (prev_stall) begin
        chk("stall_rd", 64'(bus.avm_read), 64'(prev_rd));
        chk("stall_addr", 64'(bus.avm_address), 64'(prev_addr));
        if (!prev_rd) chk("stall_data", 64'(bus.avm_writedata), 64'(prev_data));
      end
      if (bus.avm_read && !bus.avm_waitrequest) begin
        rd_cnt++;
        chk("rd_expected", 64'(exp_rd_q.size() != 0), 64'(1));
        if (exp_rd_q.size() != 0) chk("rd_addr", 64'(bus.avm_address), 64'(exp_rd_q.pop_front()));
      end
      if (bus.avm_write && !bus.avm_waitrequest) begin
        wr_cnt++;
        chk("wr_expected", 64'(exp_wa_q.size() != 0), 64'(1));
        if (exp_wa_q.size() != 0) begin
          chk("wr_addr", 64'(bus.avm_address), 64'(exp_wa_q.pop_front()));
          chk("wr_data", 64'(bus.avm_writedata), 64'(exp_wd_q.pop_front()));
        end
      end
      prev_stall = (bus.avm_read | bus.avm_write) & bus.avm_waitrequest;
      prev_rd    = bus.avm_read;
      prev_addr  = bus.avm_address;
      prev_data  = bus.avm_writedata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    for (int i = 0; i < int'(l); i++) begin
      exp_rd_q.push_back(s + 16'(i));
      exp_wa_q.push_back(d + 16'(i));
      exp_wd_q.push_back(mem[s + 16'(i)]);
    end
  endtask

  task automatic do_start(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_irq(output int n, input int budget);
    n = 0;
    while (!irq && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    chk("irq_seen", 64'(irq), 64'(1));
  endtask

  task automatic clear_irq();
    @(negedge clk);
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    chk("irq_cleared", 64'(irq), 64'(0));
  endtask

  initial begin
    int n, rd0, wr0;
    for (int i = 0; i < 65536; i++) mem[i] <= 32'h0;
    for (int i = 0; i < RL; i++) rd_pipe[i] <= 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_irq", 64'(irq), 64'(0));
    chk("rst_read", 64'(bus.avm_read), 64'(0));
    chk("rst_write", 64'(bus.avm_write), 64'(0));
    chk("rst_cs", 64'(bus.avm_chipselect), 64'(0));
    chk("rst_addr", 64'(bus.avm_address), 64'(0));
    chk("rst_wdata", 64'(bus.avm_writedata), 64'(0));
    chk("rst_words", 64'(words_done), 64'(0));
    chk("rst_be", 64'(bus.avm_byteenable), 64'(4'hF));

    // Basic 4-word copy
    for (int i = 0; i < 4; i++) mem[16'h0010 + 16'(i)] <= 32'hA0 + 32'(i);
    @(posedge clk);
    push_copy(16'h0010, 16'h0100, 16'd4);
    do_start(16'h0010, 16'h0100, 16'd4);
    chk("busy_after_start", 64'(busy), 64'(1));
    wait_irq(n, 100);
    chk("t1_irq_latency", 64'(n), 64'(13));
    chk("t1_words_done", 64'(words_done), 64'(4));
    chk("t1_busy_low", 64'(busy), 64'(0));
    for (int i = 0; i < 4; i++) chk("t1_ram", 64'(mem[16'h0100 + 16'(i)]), 64'(32'hA0 + 32'(i)));
    chk("t1_queue_empty", 64'(exp_wa_q.size()), 64'(0));
    clear_irq();

    // Random stalls
    for (int i = 0; i < 8; i++) mem[16'h0300 + 16'(i)] <= $urandom;
    @(posedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt;
    push_copy(16'h0300, 16'h0400, 16'd8);
    rand_wait = 1'b1;
    do_start(16'h0300, 16'h0400, 16'd8);
    wait_irq(n, 600);
    rand_wait = 1'b0;
    chk("t2_reads", 64'(rd_cnt - rd0), 64'(8));
    chk("t2_writes", 64'(wr_cnt - wr0), 64'(8));
    chk("t2_words_done", 64'(words_done), 64'(8));
    for (int i = 0; i < 8; i++) chk("t2_ram", 64'(mem[16'h0400 + 16'(i)]), 64'(mem[16'h0300 + 16'(i)]));
    clear_irq();

    // Address wrap
    mem[16'hFFFE] <= 32'h1111_0001;
    mem[16'hFFFF] <= 32'h2222_0002;
    mem[16'h0000] <= 32'h3333_0003;
    @(posedge clk);
    push_copy(16'hFFFE, 16'h0200, 16'd3);
    do_start(16'hFFFE, 16'h0200, 16'd3);
    wait_irq(n, 100);
    chk("t4_words_done", 64'(words_done), 64'(3));
    chk("t4_ram2", 64'(mem[16'h0202]), 64'(32'h3333_0003));
    chk("t4_queue_empty", 64'(exp_rd_q.size()), 64'(0));
    clear_irq();

    // Ignored restart, then reset mid-copy
    for (int i = 0; i < 6; i++) mem[16'h0500 + 16'(i)] <= 32'hC0DE_0000 + 32'(i);
    @(posedge clk);
    wr0 = wr_cnt;
    push_copy(16'h0500, 16'h0600, 16'd6);
    do_start(16'h0500, 16'h0600, 16'd6);
    n = 0;
    while (wr_cnt == wr0 && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t5_first_write", 64'(wr_cnt - wr0), 64'(1));
    do_start(16'h0700, 16'h0800, 16'd2);
    chk("t5_busy_kept", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
    chk("t5_rst_busy", 64'(busy), 64'(0));
    chk("t5_rst_read", 64'(bus.avm_read), 64'(0));
    chk("t5_rst_write", 64'(bus.avm_write), 64'(0));
    chk("t5_rst_addr", 64'(bus.avm_address), 64'(0));
    chk("t5_rst_wdata", 64'(bus.avm_writedata), 64'(0));
    chk("t5_rst_words", 64'(words_done), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("t5_no_reads", 64'(rd_cnt - rd0), 64'(0));
    chk("t5_no_writes", 64'(wr_cnt - wr0), 64'(0));
    chk("t5_no_irq", 64'(irq), 64'(0));
    chk("t5_idle", 64'(busy), 64'(0));

    // Zero-length start
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_start(16'h0010, 16'h0900, 16'd0);
    wait_irq(n, 20);
    chk("t3_irq_latency", 64'(n), 64'(1));
    @(posedge clk);
    #1;
    chk("t3_irq_two_cycles", 64'(irq), 64'(1));
    chk("t3_words_done", 64'(words_done), 64'(0));
    chk("t3_no_reads", 64'(rd_cnt - rd0), 64'(0));
    chk("t3_no_writes", 64'(wr_cnt - wr0), 64'(0));
    clear_irq();

    // Ack coinciding with the completion set
    do_start(16'h0010, 16'h0900, 16'd0);
    irq_ack = 1'b1;
    @(posedge clk);
    #1 irq_ack = 1'b0;
    chk("t6_set_wins", 64'(irq), 64'(1));
    @(posedge clk);
    #1;
    chk("t6_irq_sticky", 64'(irq), 64'(1));
    clear_irq();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
